// File: rtl/audio_pkg.sv
// Shared sound-effect identifiers, per-effect tone tables and sequencer state type.
package audio_pkg;

    localparam int SFX_COUNT = 4;

    localparam logic [1:0] SFX_DEATH = 2'd0;
    localparam logic [1:0] SFX_HIT   = 2'd1;
    localparam logic [1:0] SFX_SHOT  = 2'd2;
    localparam logic [1:0] SFX_STEP  = 2'd3;

    localparam int HP_W  = 11;
    localparam int LEN_W = 6;
    localparam int VOL_W = 8;

    localparam int HALF_PERIOD [SFX_COUNT] = '{600, 300, 150, 1200};
    localparam int LENGTH      [SFX_COUNT] = '{50, 20, 10, 5};
    localparam int VOLUME      [SFX_COUNT] = '{200, 160, 128, 96};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2
    } sfx_state_e;

    function automatic logic [HP_W-1:0] half_period_m1(input logic [1:0] id);
        return HP_W'(HALF_PERIOD[id] - 1);
    endfunction

    function automatic logic [LEN_W-1:0] sfx_length(input logic [1:0] id);
        return LEN_W'(LENGTH[id]);
    endfunction

    function automatic logic [VOL_W-1:0] sfx_volume(input logic [1:0] id);
        return VOL_W'(VOLUME[id]);
    endfunction

    // Bit 0 wins, so scan from the top and let lower indices overwrite.
    function automatic logic [1:0] lowest_set(input logic [SFX_COUNT-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = SFX_COUNT - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/tone_oscillator.sv
// Square-wave phase generator: a half-period down-counter toggling a phase flop.
// Exposes the phase value being registered this edge so the caller can register duty in step.
module tone_oscillator #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] half_period_m1,
    output logic             phase_next
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             phase;

    always_comb begin
        cnt_next   = cnt;
        phase_next = phase;
        if (load) begin
            cnt_next   = half_period_m1;
            phase_next = 1'b1;
        end else if (en) begin
            if (cnt == '0) begin
                cnt_next   = half_period_m1;
                phase_next = ~phase;
            end else begin
                cnt_next = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            phase <= phase_next;
        end
    end

endmodule

// File: rtl/sfx_sequencer.sv
// Priority-arbitrated sound-effect scheduler driving the PWM duty value with a gated
// square-wave tone of per-effect pitch, length and volume.
module sfx_sequencer
    import audio_pkg::*;
#(
    parameter int DUTY_WIDTH = 8,
    parameter int TICK_DIV   = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic                  mute,
    output logic [DUTY_WIDTH-1:0] duty,
    output logic                  busy,
    output logic [1:0]            active_id,
    output logic                  done
);

    localparam int PRE_W = $clog2(TICK_DIV);

    sfx_state_e            state;
    logic [3:0]            pending;
    logic [3:0]            clr_mask;
    logic [PRE_W-1:0]      pre_cnt;
    logic [LEN_W-1:0]      len_cnt;
    logic [1:0]            sel_id;
    logic                  any_pending;
    logic                  finish;
    logic                  preempt;
    logic                  take;
    logic                  phase_next;
    logic [DUTY_WIDTH-1:0] vol;

    assign any_pending = |pending;
    assign sel_id      = lowest_set(pending);
    assign vol         = DUTY_WIDTH'(sfx_volume(active_id));
    assign finish      = (state == ST_PLAY) && (len_cnt == LEN_W'(1)) && (pre_cnt == '0);
    // A natural finish outranks a simultaneous preemption so the done pulse is not lost.
    assign preempt     = (state == ST_PLAY) && !finish && any_pending && (sel_id < active_id);
    assign take        = any_pending && ((state == ST_IDLE) || finish || preempt);
    assign clr_mask    = take ? (4'b0001 << sel_id) : 4'b0000;

    tone_oscillator #(
        .CNT_W(HP_W)
    ) u_osc (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (state == ST_LOAD),
        .en            (state == ST_PLAY),
        .half_period_m1(half_period_m1(active_id)),
        .phase_next    (phase_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pending   <= '0;
            duty      <= '0;
            busy      <= 1'b0;
            active_id <= 2'd0;
            done      <= 1'b0;
            pre_cnt   <= '0;
            len_cnt   <= '0;
        end else begin
            // New requests win over the clear of the ID being loaded.
            pending <= (pending & ~clr_mask) | req;
            done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    duty <= '0;
                    if (any_pending) begin
                        state     <= ST_LOAD;
                        active_id <= sel_id;
                        busy      <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state   <= ST_PLAY;
                    pre_cnt <= PRE_W'(TICK_DIV - 1);
                    len_cnt <= sfx_length(active_id);
                    duty    <= mute ? '0 : vol;
                end
                ST_PLAY: begin
                    if (finish) begin
                        done    <= 1'b1;
                        duty    <= '0;
                        len_cnt <= '0;
                        if (any_pending) begin
                            state     <= ST_LOAD;
                            active_id <= sel_id;
                        end else begin
                            state     <= ST_IDLE;
                            active_id <= 2'd0;
                            busy      <= 1'b0;
                        end
                    end else if (preempt) begin
                        state     <= ST_LOAD;
                        active_id <= sel_id;
                        duty      <= '0;
                    end else begin
                        if (pre_cnt == '0) begin
                            pre_cnt <= PRE_W'(TICK_DIV - 1);
                            len_cnt <= len_cnt - LEN_W'(1);
                        end else begin
                            pre_cnt <= pre_cnt - PRE_W'(1);
                        end
                        duty <= (phase_next && !mute) ? vol : '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    duty  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Bench for sfx_sequencer: vector table, directed multi-cycle scenarios and random traffic
// checked against an elapsed-time reference model of the effect schedule.
module tb_sfx_sequencer;

    localparam int TD  = 4;
    localparam int TD2 = 64;

    int HP  [4] = '{600, 300, 150, 1200};
    int LEN [4] = '{50, 20, 10, 5};
    int VOL [4] = '{200, 160, 128, 96};

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       mute;
    logic [7:0] duty;
    logic       busy;
    logic [1:0] active_id;
    logic       done;

    logic [3:0] req2;
    logic       mute2;
    logic [7:0] duty2;
    logic       busy2;
    logic [1:0] active_id2;
    logic       done2;

    sfx_sequencer #(.DUTY_WIDTH(8), .TICK_DIV(TD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mute(mute),
        .duty(duty), .busy(busy), .active_id(active_id), .done(done)
    );

    // Longer tick so effects outlast a half period and the tone actually toggles.
    sfx_sequencer #(.DUTY_WIDTH(8), .TICK_DIV(TD2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .mute(mute2),
        .duty(duty2), .busy(busy2), .active_id(active_id2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: which effect runs and since when; outputs derive from elapsed time.
    int       m_t = 0;
    int       m_mode = 0;
    int       m_id = 0;
    int       m_start = 0;
    bit [3:0] m_pend = '0;
    int       e_duty = 0;
    int       e_busy = 0;
    int       e_done = 0;
    int       e_id = 0;

    int cycnum;
    int nz_cnt;
    int first_nz;
    int last_nz;
    int busy_cnt;
    int vc [4];
    int done_q [$];

    typedef struct {
        logic [3:0] r;
        logic       m;
        logic       rn;
        int         duty;
        int         busy;
        int         done;
        int         id;
    } vec_t;

    vec_t tbl [8];

    task automatic model_step(input logic [3:0] r, input logic m, input logic rn);
        int low;
        int take;
        int k;
        m_t++;
        if (!rn) begin
            m_mode = 0; m_id = 0; m_pend = '0;
            e_duty = 0; e_busy = 0; e_done = 0; e_id = 0;
            return;
        end
        low = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) low = i;
        take = -1;
        e_done = 0;
        if (m_mode == 0) begin
            e_duty = 0;
            if (low >= 0) begin
                m_mode = 1; m_id = low; take = low; e_busy = 1;
            end
        end else if (m_mode == 1) begin
            m_mode = 2;
            m_start = m_t;
            e_duty = m ? 0 : VOL[m_id];
        end else begin
            k = m_t - m_start;
            if (k == LEN[m_id] * TD) begin
                e_done = 1;
                e_duty = 0;
                if (low >= 0) begin
                    m_mode = 1; m_id = low; take = low;
                end else begin
                    m_mode = 0; m_id = 0; e_busy = 0;
                end
            end else if (low >= 0 && low < m_id) begin
                m_mode = 1; m_id = low; take = low; e_duty = 0;
            end else begin
                e_duty = (((k / HP[m_id]) % 2) == 0 && !m) ? VOL[m_id] : 0;
            end
        end
        if (take >= 0) m_pend[take] = 1'b0;
        m_pend = m_pend | r;
        e_id = m_id;
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic clr_track();
        cycnum = 0; nz_cnt = 0; first_nz = -1; last_nz = -1; busy_cnt = 0;
        for (int i = 0; i < 4; i++) vc[i] = 0;
        done_q.delete();
    endtask

    // One clock: drive inputs, advance model, sample DUT 1 time unit after the edge.
    task automatic cyc(input logic [3:0] r, input logic m, input logic rn);
        req = r; mute = m; rst_n = rn;
        model_step(r, m, rn);
        @(posedge clk);
        #1;
        cycnum++;
        tests++;
        if (int'(duty) != e_duty || int'(busy) != e_busy || int'(done) != e_done ||
            int'(active_id) != e_id) begin
            fails++;
            $display("FAIL model t=%0d: duty=%0d busy=%0b done=%0b id=%0d, expected duty=%0d busy=%0d done=%0d id=%0d",
                     m_t, duty, busy, done, active_id, e_duty, e_busy, e_done, e_id);
        end
        if (duty != 8'd0) begin
            nz_cnt++;
            if (first_nz < 0) first_nz = cycnum;
            last_nz = cycnum;
            for (int i = 0; i < 4; i++) if (int'(duty) == VOL[i]) vc[i]++;
        end
        if (done) done_q.push_back(cycnum);
        if (busy) busy_cnt++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        req = '0; mute = 1'b0; rst_n = 1'b0; req2 = '0; mute2 = 1'b0;

        // Reset, then SHOT latency and next-edge mute response.
        tbl[0] = '{4'b0000, 1'b0, 1'b0,   0, 0, 0, 0};
        tbl[1] = '{4'b0000, 1'b0, 1'b0,   0, 0, 0, 0};
        tbl[2] = '{4'b0100, 1'b0, 1'b1,   0, 0, 0, 0};
        tbl[3] = '{4'b0000, 1'b0, 1'b1,   0, 1, 0, 2};
        tbl[4] = '{4'b0000, 1'b0, 1'b1, 128, 1, 0, 2};
        tbl[5] = '{4'b0000, 1'b0, 1'b1, 128, 1, 0, 2};
        tbl[6] = '{4'b0000, 1'b1, 1'b1,   0, 1, 0, 2};
        tbl[7] = '{4'b0000, 1'b0, 1'b1, 128, 1, 0, 2};
        clr_track();
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].r, tbl[i].m, tbl[i].rn);
            tests++;
            if (int'(duty) != tbl[i].duty || int'(busy) != tbl[i].busy ||
                int'(done) != tbl[i].done || int'(active_id) != tbl[i].id) begin
                fails++;
                $display("FAIL vec%0d: duty=%0d busy=%0b done=%0b id=%0d, expected %0d %0d %0d %0d",
                         i, duty, busy, done, active_id,
                         tbl[i].duty, tbl[i].busy, tbl[i].done, tbl[i].id);
            end
        end
        idle_cycles(45);
        expect_int("vec_tail_done_count", done_q.size(), 1);
        expect_int("vec_tail_idle", int'(busy), 0);

        // SHOT alone: 40 cycles of duty 128, done on the exit edge.
        clr_track();
        cyc(4'b0100, 1'b0, 1'b1);
        idle_cycles(59);
        expect_int("shot_first_duty", first_nz, 3);
        expect_int("shot_last_duty", last_nz, 42);
        expect_int("shot_vol128", vc[2], 40);
        expect_int("shot_done_count", done_q.size(), 1);
        expect_int("shot_done_cycle", done_q.size() > 0 ? done_q[0] : -1, 43);
        expect_int("shot_idle_after", int'(busy), 0);

        // STEP preempted by DEATH; STEP never resumes.
        clr_track();
        cyc(4'b1000, 1'b0, 1'b1);
        idle_cycles(5);
        cyc(4'b0001, 1'b0, 1'b1);
        idle_cycles(1);
        expect_int("preempt_load_busy", int'(busy), 1);
        expect_int("preempt_load_id", int'(active_id), 0);
        expect_int("preempt_load_duty", int'(duty), 0);
        idle_cycles(222);
        expect_int("preempt_step_cycles", vc[3], 5);
        expect_int("preempt_death_cycles", vc[0], 200);
        expect_int("preempt_done_count", done_q.size(), 1);
        expect_int("preempt_done_cycle", done_q.size() > 0 ? done_q[0] : -1, 209);
        expect_int("preempt_last_duty", last_nz, 208);

        // HIT and SHOT together: HIT first, SHOT right after.
        clr_track();
        cyc(4'b0110, 1'b0, 1'b1);
        idle_cycles(134);
        expect_int("pair_hit_cycles", vc[1], 80);
        expect_int("pair_shot_cycles", vc[2], 40);
        expect_int("pair_done_count", done_q.size(), 2);
        expect_int("pair_done0", done_q.size() > 0 ? done_q[0] : -1, 83);
        expect_int("pair_done1", done_q.size() > 1 ? done_q[1] : -1, 124);
        expect_int("pair_last_duty", last_nz, 123);

        // SHOT retriggered mid-play replays in full afterwards.
        clr_track();
        cyc(4'b0100, 1'b0, 1'b1);
        idle_cycles(8);
        cyc(4'b0100, 1'b0, 1'b1);
        idle_cycles(85);
        expect_int("retrig_shot_cycles", vc[2], 80);
        expect_int("retrig_done_count", done_q.size(), 2);
        expect_int("retrig_done0", done_q.size() > 0 ? done_q[0] : -1, 43);
        expect_int("retrig_done1", done_q.size() > 1 ? done_q[1] : -1, 84);

        // Mute for 30 edges mid-SHOT: duty suppressed, done timing unchanged.
        clr_track();
        cyc(4'b0100, 1'b0, 1'b1);
        for (int c = 2; c <= 50; c++) cyc(4'b0000, (c >= 5 && c <= 34), 1'b1);
        expect_int("mute_audible_cycles", vc[2], 10);
        expect_int("mute_done_count", done_q.size(), 1);
        expect_int("mute_done_cycle", done_q.size() > 0 ? done_q[0] : -1, 43);

        // Reset in the middle of DEATH, with a request on the reset edge.
        clr_track();
        cyc(4'b0001, 1'b0, 1'b1);
        idle_cycles(49);
        expect_int("rst_pre_playing", int'(duty), 200);
        cyc(4'b0100, 1'b0, 1'b0);
        expect_int("rst_duty", int'(duty), 0);
        expect_int("rst_busy", int'(busy), 0);
        expect_int("rst_done", int'(done), 0);
        expect_int("rst_id", int'(active_id), 0);
        clr_track();
        idle_cycles(20);
        expect_int("rst_stays_idle", busy_cnt, 0);
        expect_int("rst_no_done", done_q.size(), 0);

        // Tone shape on the long-tick instance: 150 high, 150 low, phase starts high.
        req2 = 4'b0100;
        cyc(4'b0000, 1'b0, 1'b1);
        req2 = 4'b0000;
        for (int j = 1; j <= 660; j++) begin
            int k;
            int exp_d;
            cyc(4'b0000, 1'b0, 1'b1);
            k = j - 2;
            exp_d = (k >= 0 && k < 10 * TD2 && ((k / 150) % 2) == 0) ? 128 : 0;
            tests++;
            if (int'(duty2) != exp_d || int'(done2) != int'(j == 10 * TD2 + 2)) begin
                fails++;
                $display("FAIL tone j=%0d: duty=%0d done=%0b, expected duty=%0d done=%0d",
                         j, duty2, done2, exp_d, int'(j == 10 * TD2 + 2));
            end
        end

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] r;
            logic       m;
            logic       rn;
            r  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            m  = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 599) != 0);
            cyc(r, m, rn);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
